regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU writeback wins, a multiply/divide result that loses is parked in a 1-entry buffer.
// Optional starvation guard (macro WB_STARVE_GUARD_EN) forces the parked result out after STARVE_LIMIT-1 further losses.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_WRITE
`define REG_WRITE 1'b1
`endif

module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_wa,
  input  logic [`DATA_WIDTH-1:0] alu_wd,
  input  logic                   md_valid,
  input  logic [4:0]             md_wa,
  input  logic [`DATA_WIDTH-1:0] md_wd,
  output logic                   md_ready,
  output logic                   RegWrite,
  output logic [4:0]             we,
  output logic [`DATA_WIDTH-1:0] w_data,
  output logic                   stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1
`ifdef WB_STARVE_GUARD_EN
    ,FORCE = 2'd2
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [4:0]             buf_wa_q, buf_wa_d;
  logic [`DATA_WIDTH-1:0] buf_wd_q, buf_wd_d;
  logic                   reg_write_q, reg_write_d;
  logic [4:0]             we_q, we_d;
  logic [`DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                   win;
  logic [4:0]             win_wa;
  logic [`DATA_WIDTH-1:0] win_wd;

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(STARVE_LIMIT - 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  // Saturating increment: the counter can never wrap back below the limit.
  assign cnt_inc = (cnt_q >= CNT_LIM) ? cnt_q : cnt_q + 1'b1;
  assign stall   = (state_q == FORCE);
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign stall = 1'b0;
`endif

  assign md_ready = (state_q == IDLE);
  assign RegWrite = reg_write_q;
  assign we       = we_q;
  assign w_data   = w_data_q;

  always_comb begin
    state_d  = state_q;
    buf_wa_d = buf_wa_q;
    buf_wd_d = buf_wd_q;
    win      = 1'b0;
    win_wa   = alu_wa;
    win_wd   = alu_wd;
`ifdef WB_STARVE_GUARD_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (alu_valid) begin
          win = 1'b1;
          if (md_valid) begin
            buf_wa_d = md_wa;
            buf_wd_d = md_wd;
            state_d  = HOLD;
`ifdef WB_STARVE_GUARD_EN
            cnt_d    = '0;
`endif
          end
        end else if (md_valid) begin
          win    = 1'b1;
          win_wa = md_wa;
          win_wd = md_wd;
        end
      end
      HOLD: begin
        win = 1'b1;
        if (!alu_valid) begin
          win_wa  = buf_wa_q;
          win_wd  = buf_wd_q;
          state_d = IDLE;
        end else if (alu_wa == buf_wa_q) begin
          // Newer ALU write to the same register supersedes the parked result.
          state_d = IDLE;
        end else begin
`ifdef WB_STARVE_GUARD_EN
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_LIM) state_d = FORCE;
`endif
        end
      end
`ifdef WB_STARVE_GUARD_EN
      FORCE: begin
        win     = 1'b1;
        win_wa  = buf_wa_q;
        win_wd  = buf_wd_q;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    reg_write_d = 1'b0;
    we_d        = we_q;
    w_data_d    = w_data_q;
    if (win && (win_wa != 5'd0)) begin
      reg_write_d = `REG_WRITE;
      we_d        = win_wa;
      w_data_d    = win_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_wa_q    <= '0;
      buf_wd_q    <= '0;
      reg_write_q <= 1'b0;
      we_q        <= '0;
      w_data_q    <= '0;
`ifdef WB_STARVE_GUARD_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      buf_wa_q    <= buf_wa_d;
      buf_wd_q    <= buf_wd_d;
      reg_write_q <= reg_write_d;
      we_q        <= we_d;
      w_data_q    <= w_data_d;
`ifdef WB_STARVE_GUARD_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule
